// File: rtl/pc_unit_if.sv
// Fetch-stage control bundle for pc_unit: next-PC controls in, PC and RAS status out.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall_i;
    logic             redirect_i;
    logic [WIDTH-1:0] redirect_pc_i;
    logic             branch_i;
    logic [WIDTH-1:0] branch_pc_i;
    logic             call_i;
    logic [WIDTH-1:0] call_pc_i;
    logic             ret_i;
    logic [WIDTH-1:0] pc_out_o;
    logic [WIDTH-1:0] pc_plus_o;
    logic             ras_empty_o;
    logic             ras_full_o;
    logic             ras_underflow_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, branch_i, branch_pc_i,
               call_i, call_pc_i, ret_i,
        input  pc_out_o, pc_plus_o, ras_empty_o, ras_full_o, ras_underflow_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, branch_i, branch_pc_i,
               call_i, call_pc_i, ret_i,
        output pc_out_o, pc_plus_o, ras_empty_o, ras_full_o, ras_underflow_o
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC register with sequential increment, redirect/branch select and a circular return-address stack.
// One-cycle latency from control inputs to pc_out_o; stall_i holds PC and RAS unless redirect_i overrides it.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      nrst_i,
    pc_unit_if.slave  bus
);
    localparam int               PW      = $clog2(RAS_DEPTH);
    localparam int               CW      = PW + 1;
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_cnt;
    logic             r_underflow;

    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;
    logic             w_push;
    logic             w_pop;
    logic             w_underflow;

    assign w_pc_plus = r_pc + STEP_W;
    assign w_top_inc = r_top + 1'b1;
    assign w_top_dec = r_top - 1'b1;

    // Priority chain: redirect beats stall; ret beats call when both are raised.
    always_comb begin
        w_pc_nxt    = w_pc_plus;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (bus.redirect_i) begin
            w_pc_nxt = bus.redirect_pc_i;
        end else if (bus.stall_i) begin
            w_pc_nxt = r_pc;
        end else if (bus.ret_i) begin
            if (r_cnt != '0) begin
                w_pc_nxt = r_ras[r_top];
                w_pop    = 1'b1;
            end else begin
                w_underflow = 1'b1;
            end
        end else if (bus.call_i) begin
            w_pc_nxt = bus.call_pc_i;
            w_push   = 1'b1;
        end else if (bus.branch_i) begin
            w_pc_nxt = bus.branch_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_pc        <= RESET_PC;
            r_top       <= '0;
            r_cnt       <= '0;
            r_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            r_pc        <= w_pc_nxt;
            r_underflow <= w_underflow;
            // A push onto a full stack lands on the oldest slot; count saturates.
            if (w_push) begin
                r_top            <= w_top_inc;
                r_ras[w_top_inc] <= w_pc_plus;
                if (r_cnt != DEPTH_C) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_top <= w_top_dec;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.pc_out_o        = r_pc;
    assign bus.pc_plus_o       = w_pc_plus;
    assign bus.ras_empty_o     = (r_cnt == '0);
    assign bus.ras_full_o      = (r_cnt == DEPTH_C);
    assign bus.ras_underflow_o = r_underflow;
endmodule

// File: tb/tb_pc_unit.sv
// Directed and random stimulus for pc_unit, checked against a queue-based next-PC/RAS model.
module tb_pc_unit;
    localparam int          WIDTH = 32;
    localparam logic [31:0] RPC   = 32'h100;
    localparam int          DEPTH = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_unf;

    pc_unit_if #(.WIDTH(WIDTH)) bus ();

    pc_unit #(
        .WIDTH(WIDTH), .RESET_PC(RPC), .STEP(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},    bus.pc_out_o, m_pc);
        chk({tag, ".plus"},  bus.pc_plus_o, m_pc + 32'd4);
        chk({tag, ".empty"}, 32'(bus.ras_empty_o), 32'(m_ras.size() == 0));
        chk({tag, ".full"},  32'(bus.ras_full_o), 32'(m_ras.size() == DEPTH));
        chk({tag, ".unf"},   32'(bus.ras_underflow_o), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc  = RPC;
        m_ras = {};
        m_unf = 1'b0;
    endtask

    // Drive one cycle of controls, advance the model across the edge, then compare.
    task automatic step(input string tag, input logic rd, input logic [31:0] rd_pc,
                        input logic st, input logic rt, input logic cl,
                        input logic [31:0] cl_pc, input logic br, input logic [31:0] br_pc);
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rd_pc;
        bus.stall_i       = st;
        bus.ret_i         = rt;
        bus.call_i        = cl;
        bus.call_pc_i     = cl_pc;
        bus.branch_i      = br;
        bus.branch_pc_i   = br_pc;
        @(posedge clk);
        m_unf = 1'b0;
        if (rd) m_pc = rd_pc;
        else if (st) begin end
        else if (rt) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = m_pc + 32'd4; m_unf = 1'b1; end
        end else if (cl) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            m_pc = cl_pc;
        end else if (br) m_pc = br_pc;
        else m_pc = m_pc + 32'd4;
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic jump(input string tag, input logic [31:0] t);
        step(tag, 1, t, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic call(input string tag, input logic [31:0] t);
        step(tag, 0, 0, 0, 0, 1, t, 0, 0);
    endtask
    task automatic ret(input string tag);
        step(tag, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        bus.redirect_i = 0; bus.redirect_pc_i = 0; bus.stall_i = 0; bus.ret_i = 0;
        bus.call_i = 0; bus.call_pc_i = 0; bus.branch_i = 0; bus.branch_pc_i = 0;
        #12;
        chk_all("reset");
        chk("reset.pc_const", bus.pc_out_o, 32'h100);
        @(negedge clk);
        nrst = 1'b1;

        idle("inc1"); idle("inc2"); idle("inc3");
        chk("inc3_const", bus.pc_out_o, 32'h10C);

        step("br200", 0, 0, 0, 0, 0, 0, 1, 32'h200);
        step("stall1", 0, 0, 1, 0, 0, 0, 0, 0);
        step("stall2", 0, 0, 1, 0, 0, 0, 0, 0);
        chk("stall_const", bus.pc_out_o, 32'h200);
        step("stall_redir", 1, 32'h800, 1, 0, 0, 0, 0, 0);
        chk("redir_const", bus.pc_out_o, 32'h800);

        jump("to40", 32'h40);
        call("call1000", 32'h1000);
        call("call2000", 32'h2000);
        ret("ret1");
        chk("ret1_const", bus.pc_out_o, 32'h1004);
        ret("ret2");
        chk("ret2_const", bus.pc_out_o, 32'h44);
        chk("nest_empty", 32'(bus.ras_empty_o), 32'd1);

        jump("to0", 32'h0);
        call("ov1", 32'h10);
        call("ov2", 32'h20);
        call("ov3", 32'h30);
        call("ov4", 32'h40);
        chk("ov_full", 32'(bus.ras_full_o), 32'd1);
        call("ov5", 32'h500);
        ret("ovr1"); chk("ovr1_const", bus.pc_out_o, 32'h44);
        ret("ovr2"); chk("ovr2_const", bus.pc_out_o, 32'h34);
        ret("ovr3"); chk("ovr3_const", bus.pc_out_o, 32'h24);
        ret("ovr4"); chk("ovr4_const", bus.pc_out_o, 32'h14);
        chk("ov_empty", 32'(bus.ras_empty_o), 32'd1);

        jump("to300", 32'h300);
        ret("unf");
        chk("unf_pc", bus.pc_out_o, 32'h304);
        chk("unf_pulse", 32'(bus.ras_underflow_o), 32'd1);
        idle("unf_clr");
        chk("unf_low", 32'(bus.ras_underflow_o), 32'd0);

        jump("to4c", 32'h4C);
        call("push50", 32'h900);
        step("call_ret", 0, 0, 0, 1, 1, 32'hA00, 0, 0);
        chk("callret_pc", bus.pc_out_o, 32'h50);
        chk("callret_empty", 32'(bus.ras_empty_o), 32'd1);

        jump("tomax", 32'hFFFF_FFFC);
        chk("plus_wrap", bus.pc_plus_o, 32'h0);
        idle("wrap");
        chk("wrap_const", bus.pc_out_o, 32'h0);

        call("pre_rst", 32'h700);
        bus.call_i = 1; bus.call_pc_i = 32'h900;
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        chk_all("mid_rst");
        @(negedge clk);
        bus.call_i = 0;
        nrst = 1'b1;
        idle("post_rst");
        chk("post_rst_const", bus.pc_out_o, 32'h104);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(99) < 5,  $urandom,
                 $urandom_range(99) < 15,
                 $urandom_range(99) < 20,
                 $urandom_range(99) < 20, $urandom,
                 $urandom_range(99) < 15, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It replaces the plain load-every-cycle counter with an internal sequential increment, a stall hold, a redirect/branch target select and a small return-address stack (RAS) for call/return. The block sits at the head of the instruction-fetch path and feeds the instruction-memory address and the PC pipeline register.

## Interface
- WIDTH, 32, PC width in bits
- RESET_PC, 0, PC value loaded on reset
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries; must be a power of 2 and at least 2

- clk_i  in  1  clock; all state updates on the rising edge
- nrst_i  in  1  asynchronous, active-low reset
- stall_i  in  1  hold the PC and the RAS
- redirect_i  in  1  exception or mispredict redirect; highest priority
- redirect_pc_i  in  WIDTH  redirect target
- branch_i  in  1  taken branch or jump
- branch_pc_i  in  WIDTH  branch target
- call_i  in  1  call: jump to call_pc_i and push the return address
- call_pc_i  in  WIDTH  call target
- ret_i  in  1  return: jump to the popped RAS entry
- pc_out_o  out  WIDTH  current PC (registered)
- pc_plus_o  out  WIDTH  pc_out_o + STEP (combinational)
- ras_empty_o  out  1  RAS count == 0
- ras_full_o  out  1  RAS count == RAS_DEPTH
- ras_underflow_o  out  1  one-cycle pulse after a ret_i on an empty RAS

## Operation
- Next-PC priority is evaluated each cycle, and the first true condition wins:
  1. redirect_i: PC <= redirect_pc_i. The RAS is unchanged. This condition overrides stall_i.
  2. stall_i: PC and RAS are held. No push, no pop, no underflow pulse.
  3. ret_i with RAS not empty: PC <= top entry; pop (top pointer decrements mod RAS_DEPTH, count decrements).
  4. ret_i with RAS empty: PC <= pc_out_o + STEP; ras_underflow_o pulses; the RAS is unchanged.
  5. call_i: PC <= call_pc_i; push pc_out_o + STEP (top pointer increments mod RAS_DEPTH, entry written at the new top).
  6. branch_i: PC <= branch_pc_i.
  7. Otherwise: PC <= pc_out_o + STEP.
- When ret_i and call_i are asserted together, ret wins and the call is dropped.
- RAS is a circular buffer with a top pointer of log2(RAS_DEPTH) bits and a count of log2(RAS_DEPTH)+1 bits.
- Push when full overwrites the oldest entry. The top pointer wraps; count saturates at RAS_DEPTH.
- All PC arithmetic is modulo 2^WIDTH. pc_out_o + STEP wraps silently at the top of the address space.
- Targets are used as given. The block applies no alignment check.

## Timing
- Reset (nrst_i low, asynchronous, any time):
  - pc_out_o = RESET_PC
  - RAS count = 0, top pointer = 0, all entries = 0
  - ras_underflow_o = 0, ras_empty_o = 1, ras_full_o = 0
- Reset asserted mid-operation clears any in-flight push or pop. After release, the first edge produces RESET_PC + STEP, unless a control input is active.
- Latency is 1 cycle: the control inputs sampled at edge N determine pc_out_o after edge N.
- pc_plus_o follows pc_out_o combinationally, with zero latency.
- ras_empty_o and ras_full_o are decoded from the registered count and change on the same edge as the push or pop.
- ras_underflow_o is registered: high for exactly the one cycle after the offending edge, then low unless the underflow repeats.
- A back-to-back call then ret on consecutive cycles returns the address pushed by that call.

## Test plan
- Reset and increment (WIDTH=32, RESET_PC=0x100, STEP=4): release nrst_i with no controls for 3 edges -> pc_out_o = 0x100, 0x104, 0x108, 0x10C; ras_empty_o = 1.
- Stall versus redirect: from pc_out_o = 0x200, apply stall_i for 2 cycles -> PC stays 0x200. Then apply stall_i together with redirect_i, redirect_pc_i = 0x800 -> pc_out_o = 0x800.
- Call/return nesting: at PC 0x40, call to 0x1000; at 0x1000, call to 0x2000; then ret, then ret -> PC sequence 0x1000, 0x2000, 0x1004, 0x44; ras_empty_o = 1 at the end.
- RAS overflow (RAS_DEPTH=4): perform 5 calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40, then 4 rets -> rets return 0x44, 0x34, 0x24, 0x14; ras_full_o = 1 after the 4th call; the entry 0x4 is lost.
- Underflow: ret_i with the RAS empty at PC 0x300 -> pc_out_o = 0x304; ras_underflow_o high for 1 cycle; count stays 0.
- Simultaneous events and wrap: assert call_i and ret_i together with 1 entry (0x50) on the RAS -> PC = 0x50 and no push. Then, at pc_out_o = 0xFFFFFFFC with no controls -> pc_out_o = 0x0. Then assert nrst_i low mid-cycle -> pc_out_o = RESET_PC immediately.
